wb_complete_arbiter: RTL and testbench
======================================

// Module: wb_complete_arbiter
// PURPOSE
//  Writeback/completion end of the dispatch interface. It accepts finished results from ALU, BR and LSU.
//  It broadcasts destination-preg wakeups to all three RSs (preg1/2/3_rdy/_valid).
//  It serialises completions onto the ROB's single completion port (complete_in/rob_fu_tag).
//  It raises mispredict/mispredict_tag and squashes younger queued completions.
// PARAMETERS
//  DEPTH   4  per-FU completion FIFO entries (power of 2, >=2)
//  TAG_W   5  ROB tag width
//  PREG_W  7  physical register index width
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-low
//  alu_valid       in   1       ALU result valid
//  alu_ready       out  1       ALU FIFO can accept
//  alu_pd          in   PREG_W  ALU destination preg
//  alu_pd_we       in   1       ALU writes a destination
//  alu_rob_tag     in   TAG_W   ALU ROB tag
//  br_valid/br_ready/br_pd/br_pd_we/br_rob_tag    as ALU, branch unit
//  br_mispredict   in   1       branch resolved mispredicted
//  lsu_valid/lsu_ready/lsu_pd/lsu_pd_we/lsu_rob_tag  as ALU, LSU
//  rob_head        in   TAG_W   ROB oldest-entry tag (age reference)
//  preg1_rdy/preg2_rdy/preg3_rdy  out  PREG_W  wakeup preg: ALU/BR/LSU
//  preg1_valid/preg2_valid/preg3_valid  out  1  wakeup strobes
//  complete_out    out  1       ROB completion strobe
//  rob_fu_tag      out  TAG_W   tag being completed
//  mispredict      out  1       flush strobe to ROB/RS/skid buffers
//  mispredict_tag  out  TAG_W   mispredicted branch tag
// BEHAVIOUR
//  Reset
//   - All outputs 0 except x_ready=1.
//   - FIFOs empty; round-robin pointer = ALU.
//  Accept
//   - Handshake = x_valid && x_ready; x_ready = (count_x < DEPTH).
//   - Ready is not combinationally dependent on this cycle's pop.
//  Wakeup
//   - Handshake at edge k with pd_we=1 and pd!=0 -> preg{1,2,3}_valid=1 for exactly cycle k+1.
//   - preg{1,2,3}_rdy=pd; all three ports may fire together.
//   - Otherwise valid=0 and rdy holds its last value.
//  Queue
//   - Each handshake pushes {tag, mispredict(BR only), live=1}.
//   - Push and pop on a full FIFO in the same cycle is legal for the FIFO.
//   - x_ready still reflects the pre-pop count.
//  Arbitration
//   - Each cycle, choose one FIFO whose head is live, round-robin ALU->BR->LSU starting at the pointer.
//   - Pop it at the edge; the pointer moves to the FU after the winner.
//   - Next cycle: complete_out=1, rob_fu_tag=head tag; else complete_out=0.
//   - Handshake at edge k -> earliest complete_out in cycle k+2.
//  Dead heads
//   - A non-live head is popped silently in any cycle.
//   - It is popped in parallel with, and independent of, arbitration.
//  Mispredict
//   - When the popped winner has mispredict=1: in the next cycle mispredict=1 (one cycle) and mispredict_tag=its tag, alongside complete_out.
//   - At that same edge, every FIFO entry with age(tag) > age(branch) gets live=0, where age(t) = (t - rob_head) mod 2^TAG_W.
//   - An input handshake on that same edge whose tag is younger is dropped: no push, but its wakeup still fires.
//  Ordering and wrap
//   - Completions across FUs need not be in program order; the ROB tolerates this.
//   - FIFO pointers wrap mod DEPTH; tag ages wrap mod 32.
//  Reset mid-operation
//   - Asserting reset mid-operation immediately clears all FIFOs and outputs.
//   - No completion is emitted for flushed or reset entries.
// TESTING
//  - Reset low, then release -> all strobes 0; alu/br/lsu_ready=1; no complete_out for 5 cycles.
//  - ALU handshake pd=12, tag=3 at edge k -> preg1_valid=1, preg1_rdy=12 in k+1; complete_out=1, rob_fu_tag=3 in k+2.
//  - ALU, BR, LSU handshake the same edge (tags 4, 5, 6, pointer=ALU) -> all 3 wakeups in k+1; tags 4, 5, 6 on consecutive cycles k+2..k+4.
//  - Hold ALU valid with no pop opportunity (BR/LSU winning) until 4 pushes -> alu_ready=0; after one pop, alu_ready=1 next cycle.
//  - rob_head=30, queued ALU tags 31 and 2, BR tag 1 with mispredict -> mispredict=1 with mispredict_tag=1; tag 31 completes, tag 2 never appears.
//  - Reset asserted while 3 entries are queued -> outputs 0 at once; nothing completes after release.

Source files
------------

// File: rtl/wb_complete_arbiter.sv
// wb_complete_arbiter: per-FU completion FIFOs, wakeup broadcast, round-robin ROB completion and branch squash
module wb_complete_arbiter #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic              alu_pd_we,
  input  logic [TAG_W-1:0]  alu_rob_tag,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [PREG_W-1:0] br_pd,
  input  logic              br_pd_we,
  input  logic [TAG_W-1:0]  br_rob_tag,
  input  logic              br_mispredict,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [PREG_W-1:0] lsu_pd,
  input  logic              lsu_pd_we,
  input  logic [TAG_W-1:0]  lsu_rob_tag,
  input  logic [TAG_W-1:0]  rob_head,
  output logic [PREG_W-1:0] preg1_rdy,
  output logic [PREG_W-1:0] preg2_rdy,
  output logic [PREG_W-1:0] preg3_rdy,
  output logic              preg1_valid,
  output logic              preg2_valid,
  output logic              preg3_valid,
  output logic              complete_out,
  output logic [TAG_W-1:0]  rob_fu_tag,
  output logic              mispredict,
  output logic [TAG_W-1:0]  mispredict_tag
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [2:0]        valid_in, we_in, mp_in;
  logic [TAG_W-1:0]  tag_in [3];
  logic [PREG_W-1:0] pd_in [3];
  logic [TAG_W-1:0]  tag_q [3][DEPTH];
  logic [DEPTH-1:0]  mp_q [3];
  logic [DEPTH-1:0]  live_q [3];
  logic [DEPTH-1:0]  squash [3];
  logic [AW-1:0]     rd_q [3];
  logic [AW-1:0]     wr_q [3];
  logic [CW-1:0]     cnt_q [3];
  logic [1:0]        rr_q, win;
  logic [2:0]        ready, hs, head_live, pop, push, wake, cand;
  logic              win_any, flush;
  logic [TAG_W-1:0]  win_tag, br_age;
  logic [PREG_W-1:0] pr_q [3];
  logic [2:0]        pv_q;
  assign valid_in = {lsu_valid, br_valid, alu_valid};
  assign we_in = {lsu_pd_we, br_pd_we, alu_pd_we};
  assign mp_in = {1'b0, br_mispredict, 1'b0};
  assign tag_in[0] = alu_rob_tag;
  assign tag_in[1] = br_rob_tag;
  assign tag_in[2] = lsu_rob_tag;
  assign pd_in[0] = alu_pd;
  assign pd_in[1] = br_pd;
  assign pd_in[2] = lsu_pd;
  assign {lsu_ready, br_ready, alu_ready} = ready;
  assign {preg3_valid, preg2_valid, preg1_valid} = pv_q;
  assign preg1_rdy = pr_q[0];
  assign preg2_rdy = pr_q[1];
  assign preg3_rdy = pr_q[2];
  always_comb begin
    win_any = 1'b0;
    win = 2'd0;
    cand = 3'd0;
    for (int i = 0; i < 3; i++) begin
      ready[i] = cnt_q[i] < CW'(DEPTH);
      hs[i] = valid_in[i] && ready[i];
      head_live[i] = cnt_q[i] != '0 && live_q[i][rd_q[i]];
      wake[i] = hs[i] && we_in[i] && pd_in[i] != '0;
    end
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      cand = cand >= 3'd3 ? cand - 3'd3 : cand;
      if (!win_any && head_live[cand]) begin
        win_any = 1'b1;
        win = cand[1:0];
      end
    end
    win_tag = tag_q[win][rd_q[win]];
    flush = win_any && mp_q[win][rd_q[win]];
    br_age = win_tag - rob_head;
    // ages are measured from the ROB head so the comparison survives tag wrap
    for (int i = 0; i < 3; i++) begin
      pop[i] = (cnt_q[i] != '0 && !live_q[i][rd_q[i]]) || (win_any && win == 2'(i));
      push[i] = hs[i] && !(flush && TAG_W'(tag_in[i] - rob_head) > br_age);
      for (int j = 0; j < DEPTH; j++)
        squash[i][j] = flush && TAG_W'(tag_q[i][j] - rob_head) > br_age;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      live_q[i] <= live_q[i] & ~squash[i];
      if (push[i]) begin
        tag_q[i][wr_q[i]] <= tag_in[i];
        mp_q[i][wr_q[i]] <= mp_in[i];
        live_q[i][wr_q[i]] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        rd_q[i] <= '0;
        wr_q[i] <= '0;
        cnt_q[i] <= '0;
        pr_q[i] <= '0;
      end
      pv_q <= '0;
      rr_q <= '0;
      complete_out <= 1'b0;
      rob_fu_tag <= '0;
      mispredict <= 1'b0;
      mispredict_tag <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        rd_q[i] <= rd_q[i] + AW'(pop[i]);
        wr_q[i] <= wr_q[i] + AW'(push[i]);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        if (wake[i]) pr_q[i] <= pd_in[i];
      end
      pv_q <= wake;
      complete_out <= win_any;
      mispredict <= flush;
      if (win_any) begin
        rob_fu_tag <= win_tag;
        rr_q <= win == 2'd2 ? 2'd0 : win + 2'd1;
      end
      if (flush) mispredict_tag <= win_tag;
    end
  end
endmodule

// File: tb/tb_wb_complete_arbiter.sv
// tb_wb_complete_arbiter: random and directed stimulus against a queue-based completion model
module tb_wb_complete_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] v = '0, we = '0;
  logic [6:0] pd [3] = '{default: '0};
  logic [4:0] tg [3] = '{default: '0};
  logic bmp = 1'b0;
  logic [4:0] head = '0;
  logic alu_ready, br_ready, lsu_ready;
  logic [6:0] preg1_rdy, preg2_rdy, preg3_rdy;
  logic preg1_valid, preg2_valid, preg3_valid;
  logic complete_out, mispredict;
  logic [4:0] rob_fu_tag, mispredict_tag;
  int compared = 0, mismatched = 0, ncomp = 0;
  logic [6:0] q [3][$];
  int rr = 0;
  logic e_c = 0, e_m = 0;
  logic [4:0] e_t = '0, e_mt = '0;
  logic [2:0] e_pv = '0;
  logic [6:0] e_pr [3] = '{default: '0};
  logic [31:0] seen = '0;
  logic [4:0] mp_seen = '0;
  logic saw;
  wb_complete_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(v[0]), .alu_ready(alu_ready), .alu_pd(pd[0]), .alu_pd_we(we[0]), .alu_rob_tag(tg[0]),
    .br_valid(v[1]), .br_ready(br_ready), .br_pd(pd[1]), .br_pd_we(we[1]), .br_rob_tag(tg[1]),
    .br_mispredict(bmp),
    .lsu_valid(v[2]), .lsu_ready(lsu_ready), .lsu_pd(pd[2]), .lsu_pd_we(we[2]), .lsu_rob_tag(tg[2]),
    .rob_head(head),
    .preg1_rdy(preg1_rdy), .preg2_rdy(preg2_rdy), .preg3_rdy(preg3_rdy),
    .preg1_valid(preg1_valid), .preg2_valid(preg2_valid), .preg3_valid(preg3_valid),
    .complete_out(complete_out), .rob_fu_tag(rob_fu_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic compare_outputs();
    chk("complete_out", complete_out, e_c);
    if (e_c) chk("rob_fu_tag", rob_fu_tag, e_t);
    chk("mispredict", mispredict, e_m);
    if (e_m) chk("mispredict_tag", mispredict_tag, e_mt);
    chk("preg_valid", {preg3_valid, preg2_valid, preg1_valid}, e_pv);
    chk("preg1_rdy", preg1_rdy, e_pr[0]);
    chk("preg2_rdy", preg2_rdy, e_pr[1]);
    chk("preg3_rdy", preg3_rdy, e_pr[2]);
    if (complete_out) begin
      seen[rob_fu_tag] = 1'b1;
      ncomp++;
    end
    if (mispredict) mp_seen = mispredict_tag;
  endtask
  // what the upcoming edge must do, from the current queues and inputs
  task automatic model_step();
    logic [2:0] hs, dead;
    logic [6:0] tmp;
    logic [4:0] bt, a;
    logic fl;
    int w, f;
    w = -1;
    fl = 1'b0;
    bt = '0;
    for (int i = 0; i < 3; i++) begin
      hs[i] = v[i] && q[i].size() < DEPTH;
      dead[i] = q[i].size() > 0 && !q[i][0][6];
    end
    for (int k = 0; k < 3; k++) begin
      f = (rr + k) % 3;
      if (w < 0 && q[f].size() > 0 && q[f][0][6]) w = f;
    end
    e_c = w >= 0;
    e_m = 1'b0;
    if (w >= 0) begin
      e_t = q[w][0][4:0];
      fl = q[w][0][5];
      if (fl) begin
        e_m = 1'b1;
        e_mt = e_t;
      end
      bt = e_t - head;
      void'(q[w].pop_front());
      rr = (w + 1) % 3;
    end
    for (int i = 0; i < 3; i++) if (dead[i]) void'(q[i].pop_front());
    if (fl)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < q[i].size(); j++) begin
          tmp = q[i][j];
          a = tmp[4:0] - head;
          if (a > bt) tmp[6] = 1'b0;
          q[i][j] = tmp;
        end
    for (int i = 0; i < 3; i++) begin
      e_pv[i] = hs[i] && we[i] && pd[i] != 0;
      if (e_pv[i]) e_pr[i] = pd[i];
      a = tg[i] - head;
      if (hs[i] && !(fl && a > bt)) q[i].push_back({1'b1, (i == 1) ? bmp : 1'b0, tg[i]});
    end
  endtask
  task automatic cycle();
    chk("alu_ready", alu_ready, q[0].size() < DEPTH);
    chk("br_ready", br_ready, q[1].size() < DEPTH);
    chk("lsu_ready", lsu_ready, q[2].size() < DEPTH);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask
  task automatic do_reset();
    v = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_strobes", {complete_out, mispredict, preg3_valid, preg2_valid, preg1_valid}, 0);
    chk("rst_ready", {lsu_ready, br_ready, alu_ready}, 3'b111);
    chk("rst_tags", {rob_fu_tag, mispredict_tag}, 0);
    chk("rst_rdy", {preg3_rdy, preg2_rdy, preg1_rdy}, 0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      e_pr[i] = '0;
    end
    rr = 0;
    e_c = 0; e_m = 0; e_t = '0; e_mt = '0; e_pv = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic idle(input int n);
    v = '0;
    repeat (n) cycle();
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    idle(5);
    chk("idle_ready", {lsu_ready, br_ready, alu_ready}, 3'b111);
    // single ALU result: wakeup next cycle, completion one cycle later
    v = 3'b001; we = 3'b001; pd[0] = 7'd12; tg[0] = 5'd3;
    cycle();
    v = '0;
    chk("t2_wake", {preg1_valid, preg1_rdy}, {1'b1, 7'd12});
    cycle();
    chk("t2_comp", {complete_out, rob_fu_tag}, {1'b1, 5'd3});
    idle(3);
    // three FUs at once from pointer ALU
    do_reset();
    v = 3'b111; we = 3'b111; pd[0] = 7'd20; pd[1] = 7'd21; pd[2] = 7'd22;
    tg[0] = 5'd4; tg[1] = 5'd5; tg[2] = 5'd6; bmp = 1'b0;
    cycle();
    v = '0;
    chk("t3_wake", {preg3_valid, preg2_valid, preg1_valid}, 3'b111);
    cycle();
    chk("t3_c4", {complete_out, rob_fu_tag}, {1'b1, 5'd4});
    cycle();
    chk("t3_c5", {complete_out, rob_fu_tag}, {1'b1, 5'd5});
    cycle();
    chk("t3_c6", {complete_out, rob_fu_tag}, {1'b1, 5'd6});
    idle(2);
    // saturate all FUs until ALU backs up
    saw = 1'b0;
    v = 3'b111; we = '0;
    for (int n = 0; n < 20 && !saw; n++) begin
      for (int i = 0; i < 3; i++) tg[i] = 5'(n * 3 + i);
      cycle();
      if (!alu_ready) saw = 1'b1;
    end
    chk("t4_full", saw, 1'b1);
    v = '0;
    saw = 1'b0;
    for (int n = 0; n < 6 && !saw; n++) begin
      cycle();
      if (alu_ready) saw = 1'b1;
    end
    chk("t4_drain", saw, 1'b1);
    idle(12);
    // mispredict squashes the younger queued ALU tag
    do_reset();
    seen = '0; mp_seen = '0; head = 5'd30; we = '0;
    v = 3'b001; tg[0] = 5'd31;
    cycle();
    v = 3'b011; tg[0] = 5'd2; tg[1] = 5'd1; bmp = 1'b1;
    cycle();
    bmp = 1'b0;
    idle(8);
    chk("t5_seen31", seen[31], 1'b1);
    chk("t5_seen1", seen[1], 1'b1);
    chk("t5_not2", seen[2], 1'b0);
    chk("t5_mptag", mp_seen, 5'd1);
    // reset with three entries queued
    v = 3'b111; we = 3'b111; tg[0] = 5'd7; tg[1] = 5'd8; tg[2] = 5'd9;
    cycle();
    do_reset();
    ncomp = 0;
    idle(6);
    chk("t6_nocomp", ncomp, 0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      v = 3'($urandom);
      we = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        pd[i] = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
        tg[i] = 5'($urandom);
      end
      bmp = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 15) == 0) head = 5'($urandom);
      if (n == 300) do_reset();
      cycle();
    end
    bmp = 1'b0;
    idle(15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
